iram_refill_controller: RTL and testbench

Instruction-side refill engine that serves the core's instruction cache misses. It watches the core's miss request (i_miss, iram_address) and fetches one full cache line from the external instruction memory as BEATS = LINE_W/BUS_W sequential bus transactions. Each transaction uses a req/ack handshake. It returns the assembled line on imem_word with a one-cycle word_ready pulse. It sits directly upstream of the core's fetch unit, between the core and instruction memory.

---
 rtl/iram_refill_controller.sv | 142 ++++++++++++++
 tb/tb_iram_refill_controller.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/iram_refill_controller.sv
// Instruction-side refill engine: on an I-cache miss, fetch one cache line as BEATS bus beats and return it whole.
// Latency: miss detect to first mem_req is 1 cycle; best case miss to word_ready is BEATS+2 cycles.
// Backpressure: mem_ack low holds mem_req/mem_addr steady indefinitely; core gets one cool-down cycle after word_ready.
module iram_refill_controller #(
    parameter int PC_W   = 32,
    parameter int LINE_W = 128,
    parameter int BUS_W  = 32
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [PC_W-1:0]   iram_address,
    input  logic              i_miss,
    output logic [LINE_W-1:0] imem_word,
    output logic              word_ready,
    output logic              mem_req,
    output logic [PC_W-1:0]   mem_addr,
    input  logic              mem_ack,
    input  logic [BUS_W-1:0]  mem_rdata,
    output logic              busy
);

    // Number of bus beats per line and the counter width needed to index them.
    localparam int BEATS  = LINE_W / BUS_W;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    // Byte-offset bits inside a line; cleared to form the line-aligned base.
    localparam logic [PC_W-1:0]   LINE_MASK  = PC_W'(LINE_W / 8 - 1);
    // Byte stride between consecutive beats.
    localparam logic [PC_W-1:0]   BEAT_BYTES = PC_W'(BUS_W / 8);
    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2,
        ST_COOL = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [BEAT_W-1:0]   beat_nxt;
    logic [PC_W-1:0]     base_q, base_d;
    logic [LINE_W-1:0]   line_buf_q, line_buf_d;
    logic [LINE_W-1:0]   imem_word_q, imem_word_d;
    logic                word_ready_q, word_ready_d;
    logic                mem_req_q, mem_req_d;
    logic [PC_W-1:0]     mem_addr_q, mem_addr_d;

    // Next-state and next-output logic; every registered output is computed here.
    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        beat_nxt     = beat_q + 1'b1;
        base_d       = base_q;
        line_buf_d   = line_buf_q;
        imem_word_d  = imem_word_q;
        word_ready_d = 1'b0;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;

        case (state_q)
            ST_IDLE: begin
                if (i_miss) begin
                    // Latch the line-aligned base; the core may move the address later.
                    base_d     = iram_address & ~LINE_MASK;
                    beat_d     = '0;
                    mem_req_d  = 1'b1;
                    mem_addr_d = iram_address & ~LINE_MASK;
                    state_d    = ST_FILL;
                end
            end

            ST_FILL: begin
                // Without an ack, request and address simply hold (no timeout).
                if (mem_ack) begin
                    // Beat 0 lands in the least significant slice of the line.
                    for (int b = 0; b < BEATS; b++) begin
                        if (beat_q == BEAT_W'(b)) begin
                            line_buf_d[b*BUS_W +: BUS_W] = mem_rdata;
                        end
                    end
                    if (beat_q == LAST_BEAT) begin
                        mem_req_d = 1'b0;
                        state_d   = ST_DONE;
                    end else begin
                        // Keep the request up so back-to-back acks stream one beat per cycle.
                        beat_d     = beat_nxt;
                        mem_addr_d = base_q + PC_W'(beat_nxt) * BEAT_BYTES;
                    end
                end
            end

            ST_DONE: begin
                // The only point where the core-visible line is updated.
                imem_word_d  = line_buf_q;
                word_ready_d = 1'b1;
                mem_req_d    = 1'b0;
                state_d      = ST_COOL;
            end

            ST_COOL: begin
                // i_miss is ignored here so the fetch unit can consume the line and drop the miss.
                state_d = ST_IDLE;
            end

            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset; reset aborts any fill.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= ST_IDLE;
            beat_q       <= '0;
            base_q       <= '0;
            line_buf_q   <= '0;
            imem_word_q  <= '0;
            word_ready_q <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            base_q       <= base_d;
            line_buf_q   <= line_buf_d;
            imem_word_q  <= imem_word_d;
            word_ready_q <= word_ready_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
        end
    end

    assign imem_word  = imem_word_q;
    assign word_ready = word_ready_q;
    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_iram_refill_controller.sv
// Directed bench for iram_refill_controller: single miss, ack stalls, withdrawn miss, back-to-back misses,
// reset mid-fill and address wrap. Memory returns 0x11111111*(beat+1) XOR a per-test salt.
// Inputs change 2 time units after the rising edge; the bus monitor samples on the falling edge.
module tb_iram_refill_controller;

    localparam int PC_W   = 32;
    localparam int LINE_W = 128;
    localparam int BUS_W  = 32;

    localparam logic [127:0] LINE_PLAIN = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] LINE_SALT  = 128'hE1E1E1E1_96969696_87878787_B4B4B4B4;
    localparam logic [31:0]  SALT       = 32'hA5A5A5A5;

    logic              clk = 1'b0;
    logic              nrst;
    logic [PC_W-1:0]   iram_address;
    logic              i_miss;
    logic [LINE_W-1:0] imem_word;
    logic              word_ready;
    logic              mem_req;
    logic [PC_W-1:0]   mem_addr;
    logic              mem_ack;
    logic [BUS_W-1:0]  mem_rdata;
    logic              busy;
    logic [31:0]       salt;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int wr_count = 0;
    int wr_cyc = 0;
    int st = 0;
    int base_wr = 0;
    logic [31:0] acc[$];

    always #5 clk = ~clk;

    // Memory model: data depends on the beat position within the line.
    assign mem_rdata = (32'h11111111 * ({30'd0, mem_addr[3:2]} + 32'd1)) ^ salt;

    iram_refill_controller #(.PC_W(PC_W), .LINE_W(LINE_W), .BUS_W(BUS_W)) dut (
        .clk(clk),
        .nrst(nrst),
        .iram_address(iram_address),
        .i_miss(i_miss),
        .imem_word(imem_word),
        .word_ready(word_ready),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_ack(mem_ack),
        .mem_rdata(mem_rdata),
        .busy(busy)
    );

    // Bus monitor: cycle count, word_ready pulses and accepted beat addresses.
    always @(negedge clk) begin
        cyc++;
        if (word_ready) begin
            wr_count++;
            wr_cyc = cyc;
        end
        if (mem_req && mem_ack) acc.push_back(mem_addr);
    end

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_wr(input int target, input int budget);
        int n;
        n = 0;
        while (wr_count < target && n < budget) begin
            tick();
            n++;
        end
        if (wr_count < target) check_val("wr_timeout", 128'(wr_count), 128'(target));
    endtask

    task automatic check_addrs(input string tag, input logic [31:0] base, input int first, input int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0] e;
            e = base + 32'(4 * i);
            if (first + i < acc.size())
                check_val($sformatf("%s_a%0d", tag, i), 128'(acc[first + i]), 128'(e));
            else
                check_val($sformatf("%s_missing%0d", tag, i), 128'(acc.size()), 128'(first + i + 1));
        end
    endtask

    task automatic start_miss(input logic [31:0] addr);
        acc.delete();
        base_wr      = wr_count;
        i_miss       = 1'b1;
        iram_address = addr;
        st           = cyc;
    endtask

    // First monitor tick after start_miss is the detect cycle, hence the -1.
    task automatic check_latency(input string tag, input int exp);
        check_val(tag, 128'(wr_cyc - st - 1), 128'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nrst = 1'b0; i_miss = 1'b0; iram_address = '0; mem_ack = 1'b0; salt = '0;
        repeat (2) tick();
        check_val("rst_imem_word", 128'(imem_word), 128'd0);
        check_val("rst_word_ready", 128'(word_ready), 128'd0);
        check_val("rst_mem_req", 128'(mem_req), 128'd0);
        check_val("rst_mem_addr", 128'(mem_addr), 128'd0);
        check_val("rst_busy", 128'(busy), 128'd0);
        nrst = 1'b1;
        tick();

        // Single miss, ack tied high.
        mem_ack = 1'b1;
        start_miss(32'h0000_0104);
        wait_wr(base_wr + 1, 40);
        check_latency("single_lat", 6);
        i_miss = 1'b0;
        check_val("single_line", imem_word, LINE_PLAIN);
        repeat (4) tick();
        check_val("single_pulses", 128'(wr_count - base_wr), 128'd1);
        check_val("single_nbeats", 128'(acc.size()), 128'd4);
        check_addrs("single", 32'h100, 0, 4);
        check_val("single_req_off", 128'(mem_req), 128'd0);
        check_val("single_idle", 128'(busy), 128'd0);

        // Ack stalls for 3 cycles before beat 1.
        start_miss(32'h0000_0104);
        tick();
        tick();
        mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("stall_addr%0d", i), 128'(mem_addr), 128'h104);
            check_val($sformatf("stall_req%0d", i), 128'(mem_req), 128'd1);
            if (i < 3) tick();
        end
        mem_ack = 1'b1;
        wait_wr(base_wr + 1, 40);
        check_latency("stall_lat", 9);
        i_miss = 1'b0;
        check_val("stall_line", imem_word, LINE_PLAIN);
        check_addrs("stall", 32'h100, 0, 4);
        repeat (3) tick();

        // Miss withdrawn after beat 0, address moved to 0x200.
        salt = SALT;
        start_miss(32'h0000_0104);
        tick();
        tick();
        i_miss = 1'b0;
        iram_address = 32'h0000_0200;
        wait_wr(base_wr + 1, 40);
        check_val("wd_line", imem_word, LINE_SALT);
        repeat (4) tick();
        check_val("wd_pulses", 128'(wr_count - base_wr), 128'd1);
        check_val("wd_nbeats", 128'(acc.size()), 128'd4);
        check_addrs("wd", 32'h100, 0, 4);
        check_val("wd_idle", 128'(busy), 128'd0);

        // Back-to-back misses: i_miss held through the cool-down cycle.
        salt = '0;
        start_miss(32'h0000_0104);
        tick();
        iram_address = 32'h0000_0230;
        wait_wr(base_wr + 1, 40);
        check_val("b2b_line1", imem_word, LINE_PLAIN);
        salt = SALT;
        repeat (3) tick();
        check_val("b2b_hold", imem_word, LINE_PLAIN);
        check_val("b2b_busy2", 128'(busy), 128'd1);
        check_val("b2b_req2", 128'(mem_req), 128'd1);
        wait_wr(base_wr + 2, 40);
        i_miss = 1'b0;
        check_val("b2b_line2", imem_word, LINE_SALT);
        check_val("b2b_nbeats", 128'(acc.size()), 128'd8);
        check_addrs("b2b_first", 32'h100, 0, 4);
        check_addrs("b2b_second", 32'h230, 4, 4);
        repeat (3) tick();

        // Reset asserted while beat 2 is being requested.
        salt = '0;
        start_miss(32'h0000_0300);
        repeat (3) tick();
        check_val("rm_beat2_addr", 128'(mem_addr), 128'h308);
        nrst = 1'b0;
        #1;
        check_val("rm_req", 128'(mem_req), 128'd0);
        check_val("rm_addr", 128'(mem_addr), 128'd0);
        check_val("rm_busy", 128'(busy), 128'd0);
        check_val("rm_wr", 128'(word_ready), 128'd0);
        check_val("rm_word", imem_word, 128'd0);
        i_miss = 1'b0;
        tick();
        nrst = 1'b1;
        repeat (8) tick();
        check_val("rm_no_pulse", 128'(wr_count - base_wr), 128'd0);
        start_miss(32'h0000_0104);
        wait_wr(base_wr + 1, 40);
        check_latency("rm_fresh_lat", 6);
        i_miss = 1'b0;
        check_val("rm_fresh_line", imem_word, LINE_PLAIN);
        check_addrs("rm_fresh", 32'h100, 0, 4);
        repeat (3) tick();

        // Line at the top of the address space.
        start_miss(32'hFFFF_FFF8);
        wait_wr(base_wr + 1, 40);
        i_miss = 1'b0;
        repeat (4) tick();
        check_val("wrap_nbeats", 128'(acc.size()), 128'd4);
        check_addrs("wrap", 32'hFFFF_FFF0, 0, 4);
        check_val("wrap_line", imem_word, LINE_PLAIN);
        check_val("wrap_req_off", 128'(mem_req), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
